// File: rtl/axi2ram_rd_data_if.sv
// AXI read-data (R) channel bundle between the RAM read-data engine and its AXI consumer.
interface axi2ram_rd_data_if #(
    parameter int C_ID  = 16,
    parameter int C_RDW = 128
);
    logic             axi_rvalid;
    logic             axi_rready;
    logic [C_ID-1:0]  axi_rid;
    logic [C_RDW-1:0] axi_rdata;
    logic [1:0]       axi_rresp;
    logic             axi_rlast;

    modport master (
        output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        input  axi_rready
    );

    modport slave (
        input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
        output axi_rready
    );
endinterface

// File: rtl/axi2ram_rd_data.sv
// Turns popped RAM read commands into AXI R beats through a 2-entry output buffer.
// Define AXI2RAM_RD_OOR_CHK_EN to answer out-of-range commands with SLVERR instead of reading the RAM.
module axi2ram_rd_data #(
    parameter int C_ID     = 16,
    parameter int C_RAM_AW = 15,
    parameter int C_RDW    = 128
) (
    input  logic                       aclk_s,
    input  logic                       rst_n,
    input  logic [C_ID+C_RAM_AW+1:0]   ram_cmd_info,
    input  logic                       ram_cmd_empty,
    output logic                       ram_cmd_pop,
    output logic                       ram_cen,
    output logic [C_RAM_AW-1:0]        ram_addr,
    input  logic [C_RDW-1:0]           ram_rdata,
    axi2ram_rd_data_if.master          axi_r
);
    localparam int IW = C_ID + C_RAM_AW + 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e            state_q, state_d;
    logic              rvalid_q;
    logic              inflight_q, inflight_d;
    logic [C_ID-1:0]   tag_id_q, tag_id_d;
    logic              tag_last_q, tag_last_d;
    logic [1:0]        tag_resp_q, tag_resp_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [C_ID-1:0]   buf_id_q   [2];
    logic [C_RDW-1:0]  buf_data_q [2];
    logic [1:0]        buf_resp_q [2];
    logic              buf_last_q [2];
    logic [C_RDW-1:0]  beat_data_d;

    logic              cmd_last;
    logic [C_ID-1:0]   cmd_id;
    logic              cmd_oor;
    logic [1:0]        count;
    logic [2:0]        level;
    logic              rd_fire;

    assign cmd_last = ram_cmd_info[IW-1];
    assign cmd_id   = ram_cmd_info[IW-2 -: C_ID];
    assign ram_addr = ram_cmd_info[C_RAM_AW-1:0];

`ifdef AXI2RAM_RD_OOR_CHK_EN
    assign cmd_oor = ram_cmd_info[C_RAM_AW];
`else
    logic unused_oor_bit;
    assign unused_oor_bit = ram_cmd_info[C_RAM_AW];
    assign cmd_oor        = 1'b0;
`endif

    always_comb begin
        count = 2'd0;
        case (state_q)
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    assign rd_fire = rvalid_q & axi_r.axi_rready;

    // Entries already held or on their way, minus the one leaving this cycle, must leave room.
    assign level       = {1'b0, count} + {2'b00, inflight_q} - {2'b00, rd_fire};
    assign ram_cmd_pop = rst_n & ~ram_cmd_empty & (level < 3'd2);
    assign ram_cen     = ~(ram_cmd_pop & ~cmd_oor);

    always_comb begin
        state_d = state_q;
        case ({inflight_q, rd_fire})
            2'b10:   state_d = (state_q == EMPTY) ? ONE : FULL;
            2'b01:   state_d = (state_q == FULL) ? ONE : EMPTY;
            default: state_d = state_q;
        endcase
        wr_ptr_d    = wr_ptr_q ^ inflight_q;
        rd_ptr_d    = rd_ptr_q ^ rd_fire;
        inflight_d  = ram_cmd_pop;
        tag_id_d    = ram_cmd_pop ? cmd_id : tag_id_q;
        tag_last_d  = ram_cmd_pop ? cmd_last : tag_last_q;
        tag_resp_d  = ram_cmd_pop ? (cmd_oor ? RESP_SLVERR : RESP_OKAY) : tag_resp_q;
        // A suppressed read leaves stale RAM output on the bus, so the beat carries zeros.
        beat_data_d = (tag_resp_q == RESP_SLVERR) ? '0 : ram_rdata;
    end

    always_ff @(posedge aclk_s) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            rvalid_q   <= 1'b0;
            inflight_q <= 1'b0;
            tag_id_q   <= '0;
            tag_last_q <= 1'b0;
            tag_resp_q <= RESP_OKAY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_id_q[i]   <= '0;
                buf_data_q[i] <= '0;
                buf_resp_q[i] <= RESP_OKAY;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            rvalid_q   <= (state_d != EMPTY);
            inflight_q <= inflight_d;
            tag_id_q   <= tag_id_d;
            tag_last_q <= tag_last_d;
            tag_resp_q <= tag_resp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (inflight_q) begin
                buf_id_q[wr_ptr_q]   <= tag_id_q;
                buf_data_q[wr_ptr_q] <= beat_data_d;
                buf_resp_q[wr_ptr_q] <= tag_resp_q;
                buf_last_q[wr_ptr_q] <= tag_last_q;
            end
        end
    end

    assign axi_r.axi_rvalid = rvalid_q & rst_n;
    assign axi_r.axi_rid    = rst_n ? buf_id_q[rd_ptr_q]   : '0;
    assign axi_r.axi_rdata  = rst_n ? buf_data_q[rd_ptr_q] : '0;
    assign axi_r.axi_rresp  = rst_n ? buf_resp_q[rd_ptr_q] : RESP_OKAY;
    assign axi_r.axi_rlast  = rst_n & buf_last_q[rd_ptr_q];
endmodule

// File: tb/tb_axi2ram_rd_data.sv
// Directed bench for axi2ram_rd_data: command FIFO and RAM models, beat log, per-cycle checks.
module tb_axi2ram_rd_data;
    localparam int C_ID = 16;
    localparam int AW   = 15;
    localparam int RDW  = 128;
    localparam int IW   = C_ID + AW + 2;

    typedef struct packed {
        logic [C_ID-1:0] id;
        logic [RDW-1:0]  data;
        logic [1:0]      resp;
        logic            last;
    } beat_t;

    logic            aclk_s = 1'b0;
    logic            rst_n  = 1'b0;
    logic [IW-1:0]   ram_cmd_info;
    logic            ram_cmd_empty;
    logic            ram_cmd_pop;
    logic            ram_cen;
    logic [AW-1:0]   ram_addr;
    logic [RDW-1:0]  ram_rdata = '0;

    axi2ram_rd_data_if #(.C_ID(C_ID), .C_RDW(RDW)) axi_r ();

    axi2ram_rd_data #(.C_ID(C_ID), .C_RAM_AW(AW), .C_RDW(RDW)) dut (
        .aclk_s        (aclk_s),
        .rst_n         (rst_n),
        .ram_cmd_info  (ram_cmd_info),
        .ram_cmd_empty (ram_cmd_empty),
        .ram_cmd_pop   (ram_cmd_pop),
        .ram_cen       (ram_cen),
        .ram_addr      (ram_addr),
        .ram_rdata     (ram_rdata),
        .axi_r         (axi_r.master)
    );

    always #5 aclk_s = ~aclk_s;

    // Command FIFO model: pushed by the stimulus, popped by the DUT, flushed with reset.
    logic [IW-1:0] cmd_mem [32];
    int            cmd_head = 0;
    int            cmd_tail = 0;
    assign ram_cmd_empty = (cmd_head == cmd_tail);
    assign ram_cmd_info  = cmd_mem[cmd_head % 32];

    always @(posedge aclk_s) begin
        if (!rst_n)           cmd_head <= cmd_tail;
        else if (ram_cmd_pop) cmd_head <= cmd_head + 1;
    end

    function automatic logic [RDW-1:0] ram_word(input logic [AW-1:0] a);
        return {16{8'hA5}} ^ RDW'(a);
    endfunction

    always @(posedge aclk_s) begin
        if (!ram_cen) ram_rdata <= ram_word(ram_addr);
    end

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_pop = 0;
    int    n_rv  = 0;
    beat_t log_q[$];

    task automatic chk(input string tag, input logic [RDW-1:0] got, input logic [RDW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic last, input logic [C_ID-1:0] id, input logic [AW:0] addr);
        return {last, id, addr};
    endfunction

    task automatic push(input logic [IW-1:0] c);
        cmd_mem[cmd_tail % 32] = c;
        cmd_tail++;
    endtask

    // Inputs are set at the falling edge; settle observes what the next rising edge will see.
    task automatic settle();
        beat_t b;
        #1;
        if (ram_cmd_pop) n_pop++;
        if (axi_r.axi_rvalid) n_rv++;
        if (axi_r.axi_rvalid && axi_r.axi_rready) begin
            b = '{id: axi_r.axi_rid, data: axi_r.axi_rdata, resp: axi_r.axi_rresp, last: axi_r.axi_rlast};
            log_q.push_back(b);
            $display("beat id=%0h last=%0b resp=%0d data=%h", b.id, b.last, b.resp, b.data);
        end
    endtask

    task automatic next();
        @(negedge aclk_s);
    endtask

    task automatic clear_log();
        log_q.delete();
        n_pop = 0;
        n_rv  = 0;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [C_ID-1:0] id,
                            input logic [RDW-1:0] data, input logic [1:0] resp, input logic last);
        beat_t b;
        if (idx >= log_q.size()) begin
            chk({tag, "_present"}, 0, 1);
            return;
        end
        b = log_q[idx];
        chk({tag, "_id"},   RDW'(b.id), RDW'(id));
        chk({tag, "_data"}, b.data, data);
        chk({tag, "_resp"}, RDW'(b.resp), RDW'(resp));
        chk({tag, "_last"}, RDW'(b.last), RDW'(last));
    endtask

    logic [7:0]     rv_mask;
    logic [RDW-1:0] held_data;
    logic [C_ID-1:0] held_id;
    logic           any_pop, any_cen, any_rv;

    initial begin
        axi_r.axi_rready = 1'b0;
        rst_n = 1'b0;
        @(negedge aclk_s);
        settle();
        next();
        settle();
        chk("rst_rvalid", RDW'(axi_r.axi_rvalid), 0);
        chk("rst_pop",    RDW'(ram_cmd_pop), 0);
        chk("rst_cen",    RDW'(ram_cen), 1);
        chk("rst_rid",    RDW'(axi_r.axi_rid), 0);
        chk("rst_rdata",  axi_r.axi_rdata, 0);
        chk("rst_rresp",  RDW'(axi_r.axi_rresp), 0);
        chk("rst_rlast",  RDW'(axi_r.axi_rlast), 0);
        next();
        rst_n = 1'b1;

        // Single beat: pop and read at N, beat at N+2.
        clear_log();
        axi_r.axi_rready = 1'b1;
        push(mk(1'b1, 16'd5, 16'h0010));
        settle();
        chk("single_pop",  RDW'(ram_cmd_pop), 1);
        chk("single_cen",  RDW'(ram_cen), 0);
        chk("single_addr", RDW'(ram_addr), RDW'(15'h0010));
        next(); settle();
        chk("single_rvalid_n1", RDW'(axi_r.axi_rvalid), 0);
        next(); settle();
        chk("single_rvalid_n2", RDW'(axi_r.axi_rvalid), 1);
        chk_beat("single", 0, 16'd5, ram_word(15'h0010), 2'b00, 1'b1);
        next(); settle();
        chk("single_rvalid_n3", RDW'(axi_r.axi_rvalid), 0);
        next();

        // Four-beat burst with rready held: beats on four consecutive cycles.
        clear_log();
        rv_mask = '0;
        for (int i = 0; i < 4; i++) push(mk(i == 3, 16'd3, 16'(i)));
        for (int c = 0; c < 8; c++) begin
            settle();
            rv_mask[c] = axi_r.axi_rvalid;
            next();
        end
        chk("burst_rvalid_pattern", RDW'(rv_mask), RDW'(8'b0011_1100));
        chk("burst_count", RDW'(log_q.size()), 4);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("burst%0d", i), i, 16'd3, ram_word(15'(i)), 2'b00, i == 3);

        // Backpressure: only two pops while rready is low, head held steady.
        clear_log();
        axi_r.axi_rready = 1'b0;
        for (int i = 0; i < 4; i++) push(mk(i == 3, 16'd9, 16'(16'h0020 + i)));
        held_data = '0;
        held_id   = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            if (c == 2) begin
                held_data = axi_r.axi_rdata;
                held_id   = axi_r.axi_rid;
            end
            next();
        end
        chk("bp_pops", RDW'(n_pop), 2);
        settle();
        chk("bp_pop_blocked", RDW'(ram_cmd_pop), 0);
        chk("bp_rvalid", RDW'(axi_r.axi_rvalid), 1);
        chk("bp_head_first", held_data, ram_word(15'h0020));
        chk("bp_head_stable_data", axi_r.axi_rdata, held_data);
        chk("bp_head_stable_id", RDW'(axi_r.axi_rid), RDW'(held_id));
        next();
        axi_r.axi_rready = 1'b1;
        for (int c = 0; c < 20 && log_q.size() < 4; c++) begin
            settle();
            next();
        end
        chk("bp_count", RDW'(log_q.size()), 4);
        chk("bp_total_pops", RDW'(n_pop), 4);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("bp%0d", i), i, 16'd9, ram_word(15'(15'h0020 + i)), 2'b00, i == 3);
        for (int c = 0; c < 3; c++) begin settle(); next(); end
        chk("bp_no_extra", RDW'(log_q.size()), 4);

        // Empty command FIFO: nothing moves whatever rready does.
        clear_log();
        any_pop = 1'b0; any_cen = 1'b0; any_rv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            axi_r.axi_rready = c[0];
            settle();
            any_pop |= ram_cmd_pop;
            any_cen |= ~ram_cen;
            any_rv  |= axi_r.axi_rvalid;
            next();
        end
        chk("empty_pop", RDW'(any_pop), 0);
        chk("empty_cen", RDW'(any_cen), 0);
        chk("empty_rvalid", RDW'(any_rv), 0);

        // Reset after two of four beats have been popped.
        clear_log();
        axi_r.axi_rready = 1'b0;
        for (int i = 0; i < 4; i++) push(mk(i == 3, 16'h000B, 16'(16'h0040 + i)));
        settle(); next();
        settle(); next();
        chk("mid_pops", RDW'(n_pop), 2);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_rvalid", RDW'(axi_r.axi_rvalid), 0);
        chk("mid_rst_pop", RDW'(ram_cmd_pop), 0);
        chk("mid_rst_cen", RDW'(ram_cen), 1);
        next();
        rst_n = 1'b1;
        settle();
        chk("mid_after_rvalid", RDW'(axi_r.axi_rvalid), 0);
        next();
        clear_log();
        axi_r.axi_rready = 1'b1;
        for (int c = 0; c < 6; c++) begin settle(); next(); end
        chk("mid_no_stale_beats", RDW'(log_q.size()), 0);
        chk("mid_no_stale_rvalid", RDW'(n_rv), 0);

        // Out-of-range command: checked build answers SLVERR without a RAM read.
        clear_log();
        push(mk(1'b1, 16'd7, {1'b1, 15'h0020}));
        settle();
        chk("oor_pop", RDW'(ram_cmd_pop), 1);
`ifdef AXI2RAM_RD_OOR_CHK_EN
        chk("oor_cen", RDW'(ram_cen), 1);
`else
        chk("oor_cen", RDW'(ram_cen), 0);
`endif
        next(); settle();
        next(); settle();
        chk("oor_rvalid", RDW'(axi_r.axi_rvalid), 1);
`ifdef AXI2RAM_RD_OOR_CHK_EN
        chk_beat("oor", 0, 16'd7, '0, 2'b10, 1'b1);
`else
        chk_beat("oor", 0, 16'd7, ram_word(15'h0020), 2'b00, 1'b1);
`endif
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
